// File: rtl/pix_pkg.sv
// Shared types and constants for the pixel-stream generator.
package pix_pkg;

  localparam int unsigned PixWidth = 12;

  // Test-pattern selector encoding
  typedef enum logic [1:0] {
    PatFrame = 2'd0,
    PatCol   = 2'd1,
    PatRow   = 2'd2,
    PatSeed  = 2'd3
  } pat_e;

  // Frame sequencer state encoding
  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLead  = 3'd1;
  localparam state_t StLine  = 3'd2;
  localparam state_t StHblk  = 3'd3;
  localparam state_t StTrail = 3'd4;
  localparam state_t StVblk  = 3'd5;

endpackage

// File: rtl/pix_pattern_data.sv
// Registered pixel-data generator; one cycle behind its inputs, like LV.
module pix_pattern_data
  import pix_pkg::*;
#(
  parameter int unsigned PixW = 12,
  parameter int unsigned RowW = 4,
  parameter int unsigned ColW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            line_active_i,
  input  pat_e            pattern_i,
  input  logic [PixW-1:0] seed_i,
  input  logic [RowW-1:0] row_i,
  input  logic [ColW-1:0] col_i,
  input  logic [15:0]     frame_count_i,
  output logic [PixW-1:0] pix_d_o
);

  logic [PixW-1:0] pix_d_d;
  logic [PixW-1:0] pix_d_q;

  // Select pattern base and add seed; force zero outside the active line
  always_comb begin
    pix_d_d = '0;
    if (line_active_i) begin
      unique case (pattern_i)
        PatFrame: pix_d_d = PixW'(frame_count_i) + seed_i;
        PatCol:   pix_d_d = PixW'(col_i) + seed_i;
        PatRow:   pix_d_d = PixW'(row_i) + seed_i;
        default:  pix_d_d = seed_i;
      endcase
    end
  end

  // Output register
  always_ff @(posedge clk_i) begin
    if (rst_i) pix_d_q <= '0;
    else       pix_d_q <= pix_d_d;
  end

  assign pix_d_o = pix_d_q;

endmodule

// File: rtl/pix_stream_gen.sv
// Image-sensor emulator: drives FV/LV/data frames with blanking and test patterns.
module pix_stream_gen
  import pix_pkg::*;
#(
  parameter int unsigned PixWidth    = pix_pkg::PixWidth,
  parameter int unsigned ImageWidth  = 16,
  parameter int unsigned ImageHeight = 8,
  parameter int unsigned FrameLead   = 2,
  parameter int unsigned HBlank      = 4,
  parameter int unsigned FrameTrail  = 2,
  parameter int unsigned VBlank      = 8
) (
  input  logic                pix_clk,
  input  logic                pix_rst,
  input  logic                en,
  input  logic [1:0]          pattern,
  input  logic [PixWidth-1:0] seed,
  output logic                pix_frameValid,
  output logic                pix_lineValid,
  output logic [PixWidth-1:0] pix_d,
  output logic                frameDone,
  output logic [15:0]         frameCount
);

  localparam int unsigned Max1   = (FrameLead > ImageWidth) ? FrameLead : ImageWidth;
  localparam int unsigned Max2   = (HBlank > FrameTrail) ? HBlank : FrameTrail;
  localparam int unsigned Max3   = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned MaxLen = (Max3 > VBlank) ? Max3 : VBlank;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);
  localparam int unsigned RowW   = $clog2(ImageHeight + 1);
  localparam int unsigned ColW   = $clog2(ImageWidth + 1);

  state_t              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [RowW-1:0]     row_q, row_d;
  pat_e                pat_q, pat_d;
  logic [PixWidth-1:0] seed_q, seed_d;
  logic                fv_q, fv_d;
  logic                lv_q, lv_d;
  logic                done_q, done_d;
  logic [15:0]         fcnt_q, fcnt_d;

  // Next-state and registered-output logic; outputs follow the state by one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    row_d   = row_q;
    pat_d   = pat_q;
    seed_d  = seed_q;
    fv_d    = (state_q == StLead) || (state_q == StLine) ||
              (state_q == StHblk) || (state_q == StTrail);
    lv_d    = (state_q == StLine);
    done_d  = (state_q == StVblk) && (cnt_q == '0);
    fcnt_d  = fcnt_q + 16'(done_d);

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en) begin
          state_d = StLead;
          pat_d   = pat_e'(pattern);
          seed_d  = seed;
        end
      end
      StLead: begin
        if (cnt_q == CntW'(FrameLead - 1)) begin
          state_d = StLine;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      StLine: begin
        if (cnt_q == CntW'(ImageWidth - 1)) begin
          cnt_d   = '0;
          state_d = (row_q == RowW'(ImageHeight - 1)) ? StTrail : StHblk;
        end
      end
      StHblk: begin
        if (cnt_q == CntW'(HBlank - 1)) begin
          state_d = StLine;
          cnt_d   = '0;
          row_d   = row_q + RowW'(1);
        end
      end
      StTrail: begin
        if (cnt_q == CntW'(FrameTrail - 1)) begin
          state_d = StVblk;
          cnt_d   = '0;
        end
      end
      StVblk: begin
        if (cnt_q == CntW'(VBlank - 1)) begin
          cnt_d = '0;
          if (en) begin
            state_d = StLead;
            pat_d   = pat_e'(pattern);
            seed_d  = seed;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      row_q   <= '0;
      pat_q   <= PatFrame;
      seed_q  <= '0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      seed_q  <= seed_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  pix_pattern_data #(
    .PixW (PixWidth),
    .RowW (RowW),
    .ColW (ColW)
  ) u_data (
    .clk_i         (pix_clk),
    .rst_i         (pix_rst),
    .line_active_i (state_q == StLine),
    .pattern_i     (pat_q),
    .seed_i        (seed_q),
    .row_i         (row_q),
    .col_i         (ColW'(cnt_q)),
    .frame_count_i (fcnt_q),
    .pix_d_o       (pix_d)
  );

  assign pix_frameValid = fv_q;
  assign pix_lineValid  = lv_q;
  assign frameDone      = done_q;
  assign frameCount     = fcnt_q;

endmodule

// File: tb/tb_pix_stream_gen.sv
// Directed bench for pix_stream_gen at default geometry (168-cycle frame period).
module tb_pix_stream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pattern;
  logic [11:0] seed;
  logic        fv, lv, done;
  logic [11:0] d;
  logic [15:0] fc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam int Depth = 600;
  logic        fv_a   [0:Depth-1];
  logic        lv_a   [0:Depth-1];
  logic        done_a [0:Depth-1];
  logic [11:0] d_a    [0:Depth-1];
  logic [15:0] fc_a   [0:Depth-1];

  // Background monitor state
  int inv_viol   = 0;
  int width_viol = 0;
  int lv_since   = 0;
  int frames_ok  = 0;
  int frames_bad = 0;
  logic prev_fv   = 1'b0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  pix_stream_gen dut (
    .pix_clk        (clk),
    .pix_rst        (rst),
    .en             (en),
    .pattern        (pattern),
    .seed           (seed),
    .pix_frameValid (fv),
    .pix_lineValid  (lv),
    .pix_d          (d),
    .frameDone      (done),
    .frameCount     (fc)
  );

  // Continuous protocol monitor: LV within FV, done width, LV cycles per frame
  always @(negedge clk) begin
    if (lv && !fv) inv_viol++;
    if (done && prev_done) width_viol++;
    if (fv && !prev_fv) lv_since = 0;
    if (lv) lv_since++;
    if (done) begin
      if (lv_since == 128) frames_ok++;
      else frames_bad++;
    end
    prev_fv   = fv;
    prev_done = done;
  end

  // Record n cycles; index i is the view after the i-th posedge
  task automatic capture(input int n, input int drop_at, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fv_a[i] = fv; lv_a[i] = lv; done_a[i] = done; d_a[i] = d; fc_a[i] = fc;
      if (i == drop_at) en = 1'b0;
      if (i == rst_at) rst = 1'b1;
      if (i == rst_at + 1) rst = 1'b0;
    end
  endtask

  function automatic int count_fv(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (fv_a[i]) c++;
    return c;
  endfunction

  function automatic int count_lv(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (lv_a[i]) c++;
    return c;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (done_a[i]) c++;
    return c;
  endfunction

  function automatic int first_lv(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (lv_a[i]) return i;
    return -1;
  endfunction

  function automatic int first_done(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (done_a[i]) return i;
    return -1;
  endfunction

  function automatic int lv_rises(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (lv_a[i] && (i == 0 || !lv_a[i-1])) c++;
    return c;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; pattern = 2'd0; seed = 12'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (fv !== 1'b0) $display("FAIL reset_fv: got %0b expected 0", fv); else pass_cnt++;
    total_cnt++; if (lv !== 1'b0) $display("FAIL reset_lv: got %0b expected 0", lv); else pass_cnt++;
    total_cnt++; if (d !== 12'h0) $display("FAIL reset_d: got %0h expected 0", d); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else pass_cnt++;
    total_cnt++; if (fc !== 16'h0) $display("FAIL reset_fc: got %0h expected 0", fc); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_frame();
    int bad;
    pattern = 2'd1; seed = 12'h0; en = 1'b1;
    capture(200, 100, -1);
    total_cnt++; if (fv_a[0] !== 1'b0) $display("FAIL ff_fv0: got %0b expected 0", fv_a[0]); else pass_cnt++;
    total_cnt++; if (fv_a[1] !== 1'b1) $display("FAIL ff_fv1: got %0b expected 1", fv_a[1]); else pass_cnt++;
    total_cnt++; if (first_lv(0, 199) !== 3) $display("FAIL ff_first_lv: got %0d expected 3", first_lv(0, 199)); else pass_cnt++;
    bad = 0;
    for (int j = 0; j < 16; j++) if (d_a[3 + j] !== 12'(j)) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL ff_line0_cols: got %0d bad pixels expected 0", bad); else pass_cnt++;
    total_cnt++; if (lv_rises(0, 199) !== 8) $display("FAIL ff_lv_pulses: got %0d expected 8", lv_rises(0, 199)); else pass_cnt++;
    total_cnt++; if (count_lv(0, 199) !== 128) $display("FAIL ff_lv_cycles: got %0d expected 128", count_lv(0, 199)); else pass_cnt++;
    total_cnt++; if (count_lv(19, 22) !== 0) $display("FAIL ff_hblank: got %0d expected 0", count_lv(19, 22)); else pass_cnt++;
    total_cnt++; if (count_fv(0, 199) !== 160) $display("FAIL ff_fv_cycles: got %0d expected 160", count_fv(0, 199)); else pass_cnt++;
    total_cnt++; if (first_done(0, 199) !== 161) $display("FAIL ff_done_cycle: got %0d expected 161", first_done(0, 199)); else pass_cnt++;
    total_cnt++; if (count_done(0, 199) !== 1) $display("FAIL ff_done_count: got %0d expected 1", count_done(0, 199)); else pass_cnt++;
    total_cnt++; if (fc_a[160] !== 16'd0) $display("FAIL ff_fc_before: got %0d expected 0", fc_a[160]); else pass_cnt++;
    total_cnt++; if (fc_a[161] !== 16'd1) $display("FAIL ff_fc_after: got %0d expected 1", fc_a[161]); else pass_cnt++;
  endtask

  task automatic test_frame_pattern();
    int bad;
    reset_dut();
    pattern = 2'd0; seed = 12'h100; en = 1'b1;
    capture(560, 386, -1);
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if (fv_a[1 + 168*k] !== 1'b1 || fv_a[168*k] !== 1'b0)
        $display("FAIL fp_fv_rise%0d: got %0b%0b expected 01", k, fv_a[168*k], fv_a[1 + 168*k]); else pass_cnt++;
      bad = 0;
      for (int i = 168*k; i < 168*k + 168; i++) if (lv_a[i] && d_a[i] !== 12'(12'h100 + k)) bad++;
      total_cnt++; if (bad !== 0) $display("FAIL fp_pixels%0d: got %0d bad pixels expected 0", k, bad); else pass_cnt++;
      total_cnt++; if (done_a[161 + 168*k] !== 1'b1 || fc_a[161 + 168*k] !== 16'(k + 1))
        $display("FAIL fp_done%0d: got done=%0b fc=%0d expected done=1 fc=%0d", k, done_a[161 + 168*k], fc_a[161 + 168*k], k + 1); else pass_cnt++;
    end
    total_cnt++; if (count_lv(0, 559) !== 384) $display("FAIL fp_lv_cycles: got %0d expected 384", count_lv(0, 559)); else pass_cnt++;
    total_cnt++; if (count_fv(504, 559) !== 0) $display("FAIL fp_idle_after: got %0d expected 0", count_fv(504, 559)); else pass_cnt++;
  endtask

  task automatic test_row_wrap();
    int bad;
    pattern = 2'd2; seed = 12'hFFE; en = 1'b1;
    capture(200, 60, -1);
    total_cnt++; if (d_a[3] !== 12'hFFE) $display("FAIL rw_row0: got %0h expected ffe", d_a[3]); else pass_cnt++;
    total_cnt++; if (d_a[23] !== 12'hFFF) $display("FAIL rw_row1: got %0h expected fff", d_a[23]); else pass_cnt++;
    total_cnt++; if (d_a[58] !== 12'h000) $display("FAIL rw_row2: got %0h expected 0", d_a[58]); else pass_cnt++;
    total_cnt++; if (d_a[143] !== 12'h005) $display("FAIL rw_row7: got %0h expected 5", d_a[143]); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 200; i++) if (!lv_a[i] && d_a[i] !== 12'h0) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL rw_d_zero_blank: got %0d nonzero expected 0", bad); else pass_cnt++;
  endtask

  task automatic test_en_drop();
    pattern = 2'd1; seed = 12'h0; en = 1'b1;
    capture(200, 50, -1);
    total_cnt++; if (count_lv(0, 199) !== 128) $display("FAIL ed_lv_cycles: got %0d expected 128", count_lv(0, 199)); else pass_cnt++;
    total_cnt++; if (first_done(0, 199) !== 161) $display("FAIL ed_done_cycle: got %0d expected 161", first_done(0, 199)); else pass_cnt++;
    total_cnt++; if (count_fv(161, 199) !== 0) $display("FAIL ed_stay_idle: got %0d expected 0", count_fv(161, 199)); else pass_cnt++;
    en = 1'b1;
    capture(3, -1, -1);
    total_cnt++; if (fv_a[0] !== 1'b0 || fv_a[1] !== 1'b1)
      $display("FAIL ed_restart_latency: got %0b%0b expected 01", fv_a[0], fv_a[1]); else pass_cnt++;
    capture(200, 0, -1);
  endtask

  task automatic test_reset_mid();
    pattern = 2'd2; seed = 12'h005; en = 1'b1;
    capture(120, -1, 70);
    total_cnt++; if (lv_a[70] !== 1'b1 || d_a[70] !== 12'h008)
      $display("FAIL rm_line3: got lv=%0b d=%0h expected lv=1 d=8", lv_a[70], d_a[70]); else pass_cnt++;
    total_cnt++; if (fc_a[70] !== 16'd6) $display("FAIL rm_fc_before: got %0d expected 6", fc_a[70]); else pass_cnt++;
    total_cnt++; if (fv_a[71] !== 1'b0 || lv_a[71] !== 1'b0 || d_a[71] !== 12'h0 || done_a[71] !== 1'b0 || fc_a[71] !== 16'h0)
      $display("FAIL rm_cleared: got fv=%0b lv=%0b d=%0h done=%0b fc=%0d expected all 0", fv_a[71], lv_a[71], d_a[71], done_a[71], fc_a[71]); else pass_cnt++;
    total_cnt++; if (count_done(0, 119) !== 0) $display("FAIL rm_no_done: got %0d expected 0", count_done(0, 119)); else pass_cnt++;
    total_cnt++; if (fv_a[72] !== 1'b0 || fv_a[73] !== 1'b1)
      $display("FAIL rm_restart: got %0b%0b expected 01", fv_a[72], fv_a[73]); else pass_cnt++;
    total_cnt++; if (first_lv(72, 119) !== 75 || d_a[75] !== 12'h005)
      $display("FAIL rm_row0: got lv_at=%0d d=%0h expected lv_at=75 d=5", first_lv(72, 119), d_a[75]); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_invariants();
    total_cnt++; if (inv_viol !== 0) $display("FAIL inv_lv_in_fv: got %0d violations expected 0", inv_viol); else pass_cnt++;
    total_cnt++; if (width_viol !== 0) $display("FAIL inv_done_width: got %0d violations expected 0", width_viol); else pass_cnt++;
    total_cnt++; if (frames_bad !== 0) $display("FAIL inv_lv_per_frame: got %0d bad frames expected 0", frames_bad); else pass_cnt++;
    total_cnt++; if (frames_ok !== 7) $display("FAIL inv_frames_done: got %0d expected 7", frames_ok); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pattern = 2'd0; seed = 12'h0;
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_frame_pattern();
    test_row_wrap();
    test_en_drop();
    test_reset_mid();
    test_invariants();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
